// File: rtl/lstm_gate_scheduler.sv
// rtl/lstm_gate_scheduler.sv - sequences the shared LSTM gate datapath across the gates of one timestep
//
// Optional feature macro: LSTM_GATE_SCHED_WATCHDOG_EN (WAIT-state watchdog driving error).
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start            begin one timestep (sampled only in IDLE)
//   gate_en          per-gate enable mask, captured when start is accepted
//   data_ready       gate datapath completion level (held until the gate is reset)
//   gate_output      gate datapath result vector
//   gate_sel         weight-bank / bias select for the gate being computed
//   gate_reset       reset to the gate datapath
//   begin_calc       one-cycle start pulse to the gate datapath
//   result           gate k's captured vector in slice [k*LAYER_BITWIDTH +: LAYER_BITWIDTH]
//   busy             high in every state except IDLE
//   done             one-cycle pulse at the end of the timestep
//   error            sticky watchdog flag (constant 0 when the watchdog is not built)

module lstm_gate_scheduler #(
    parameter int HIDDEN_SZ      = 32,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int NUM_GATES      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BITWIDTH       = QN + QM + 1,
    localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
    localparam int SEL_W          = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_GATES-1:0]                gate_en,
    input  logic                                data_ready,
    input  logic [LAYER_BITWIDTH-1:0]           gate_output,
    output logic [SEL_W-1:0]                    gate_sel,
    output logic                                gate_reset,
    output logic                                begin_calc,
    output logic [NUM_GATES*LAYER_BITWIDTH-1:0] result,
    output logic                                busy,
    output logic                                done,
    output logic                                error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_CLR,
        S_GO,
        S_WAIT,
        S_CAP,
        S_FIN
    } state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_GATES - 1);

    state_t               state;
    logic [SEL_W-1:0]     ptr;
    logic [NUM_GATES-1:0] mask;
    logic                 ready_q;

`ifdef LSTM_GATE_SCHED_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             error_q;
    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign error = 1'b0;
`endif

    // Outputs are assigned for the state being entered, so each one is a
    // clean register that is valid for the whole cycle of that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            mask       <= '0;
            ready_q    <= 1'b0;
            gate_sel   <= '0;
            gate_reset <= 1'b1;
            begin_calc <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef LSTM_GATE_SCHED_WATCHDOG_EN
            wd_cnt     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            // Previous-cycle data_ready: only a fresh rise inside WAIT counts,
            // so a level left over from an earlier computation is ignored.
            ready_q    <= data_ready;
            done       <= 1'b0;
            begin_calc <= 1'b0;

            case (state)
                S_IDLE: begin
                    gate_reset <= 1'b1;
                    if (start) begin
                        mask       <= gate_en;
                        ptr        <= '0;
                        busy       <= 1'b1;
                        gate_reset <= 1'b0;
                        state      <= S_SEEK;
                    end
                end

                S_SEEK: begin
                    if (mask[ptr]) begin
                        gate_sel   <= ptr;
                        gate_reset <= 1'b1;
                        state      <= S_CLR;
                    end else if (ptr == LAST) begin
                        done       <= 1'b1;
                        gate_reset <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end

                S_CLR: begin
                    gate_reset <= 1'b0;
                    begin_calc <= 1'b1;
                    state      <= S_GO;
                end

                S_GO: begin
`ifdef LSTM_GATE_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (data_ready && !ready_q) begin
                        state <= S_CAP;
`ifdef LSTM_GATE_SCHED_WATCHDOG_EN
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Gate never answered: abandon the timestep without
                        // touching this gate's slice.
                        error_q    <= 1'b1;
                        done       <= 1'b1;
                        gate_reset <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end

                S_CAP: begin
                    for (int k = 0; k < NUM_GATES; k++) begin
                        if (ptr == SEL_W'(k)) begin
                            result[k*LAYER_BITWIDTH +: LAYER_BITWIDTH] <= gate_output;
                        end
                    end
                    if (ptr == LAST) begin
                        done       <= 1'b1;
                        gate_reset <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= S_SEEK;
                    end
                end

                S_FIN: begin
                    busy       <= 1'b0;
                    gate_reset <= 1'b1;
                    state      <= S_IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    gate_reset <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// tb/tb_lstm_gate_scheduler.sv - self-checking bench for lstm_gate_scheduler
module tb_lstm_gate_scheduler;

    localparam int HS  = 32;
    localparam int NG  = 4;
    localparam int BW  = 18;
    localparam int LB  = BW * HS;
    localparam int LAT = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [NG-1:0]     gate_en;
    logic              data_ready;
    logic [LB-1:0]     gate_output;
    logic [1:0]        gate_sel;
    logic              gate_reset;
    logic              begin_calc;
    logic [NG*LB-1:0]  result;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clock = ~clock;

    lstm_gate_scheduler #(
        .HIDDEN_SZ(HS), .QN(6), .QM(11), .NUM_GATES(NG), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .gate_en(gate_en),
        .data_ready(data_ready), .gate_output(gate_output), .gate_sel(gate_sel),
        .gate_reset(gate_reset), .begin_calc(begin_calc), .result(result),
        .busy(busy), .done(done), .error(error)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Gate datapath model: mode 0 normal, 1 stale level (ignores gate reset,
    // drops and re-raises data_ready), 2 never responds.
    int mode  = 0;
    int salt  = 0;
    int cdown = -1;

    function automatic logic [LB-1:0] pattern(input int idx, input int s);
        logic [LB-1:0] v;
        logic [BW-1:0] w;
        for (int j = 0; j < HS; j++) begin
            w = 18'h00400 ^ BW'(idx);
            if (s != 0) w = w ^ BW'(s << 12) ^ BW'(j << 4);
            v[j*BW +: BW] = w;
        end
        return v;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            cdown = -1;
            if (mode != 1) data_ready = 1'b0;
        end else begin
            if (gate_reset && mode != 1) begin
                data_ready = 1'b0;
                cdown      = -1;
            end
            if (begin_calc && mode != 2) begin
                cdown = LAT;
            end else if (cdown > 0) begin
                cdown--;
                if (mode == 1 && cdown == 5) begin
                    data_ready  = 1'b0;
                    gate_output = '1;
                end
                if (cdown == 0) begin
                    data_ready  = 1'b1;
                    gate_output = pattern(int'(gate_sel), salt);
                    cdown       = -1;
                end
            end
        end
    end

    // Per-cycle protocol compare; records the order in which gates are started.
    logic prev_gr = 1'b1, prev2_gr = 1'b1, prev_bc = 1'b0, prev_done = 1'b0;
    logic exp_error = 1'b0;
    int   seq[$];
    int   done_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (begin_calc) begin
                check("reset_then_begin", {61'd0, prev2_gr, prev_gr, gate_reset}, 64'b010);
                check("begin_calc_width", prev_bc, 0);
                seq.push_back(int'(gate_sel));
            end
            if (done) begin
                check("done_width", prev_done, 0);
                check("busy_at_done", busy, 1);
                check("error_at_done", error, exp_error);
                done_cnt++;
            end
        end
        prev2_gr  = prev_gr;
        prev_gr   = gate_reset;
        prev_bc   = begin_calc;
        prev_done = done;
    end

    logic [LB-1:0] exp_res [NG];

    function automatic int model_latency(input logic [NG-1:0] m);
        int n = 1;
        for (int k = 0; k < NG; k++) n += m[k] ? (3 + LAT + 1) : 1;
        return n;
    endfunction

    task automatic check_results(input string tag);
        for (int k = 0; k < NG; k++)
            check_wide($sformatf("%s_slice%0d", tag, k), result[k*LB +: LB], exp_res[k]);
    endtask

    // One timestep: start, optional start poke while busy, wait for done.
    task automatic run(input logic [NG-1:0] m, input int md, input int s,
                       input int exp_cycles, input int poke_at);
        int cyc;
        int exp_seq[$];
        mode = md;
        salt = s;
        seq.delete();
        done_cnt = 0;
        gate_en  = m;
        start    = 1'b1;
        cyc      = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (poke_at != 0 && cyc == poke_at) begin
                start   = 1'b1;
                gate_en = ~m;
            end
            if (poke_at != 0 && cyc == poke_at + 1) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        check($sformatf("latency_%b", m), cyc, exp_cycles);
        if (md == 2) begin
            for (int k = 0; k < NG; k++) if (m[k]) begin exp_seq.push_back(k); break; end
        end else begin
            for (int k = 0; k < NG; k++) if (m[k]) exp_seq.push_back(k);
        end
        check($sformatf("gate_count_%b", m), seq.size(), exp_seq.size());
        for (int k = 0; k < exp_seq.size() && k < seq.size(); k++)
            check($sformatf("gate_order_%b_%0d", m, k), seq[k], exp_seq[k]);
        @(posedge clock); #1;
        check("done_pulses", done_cnt, 1);
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("gate_reset_idle", gate_reset, 1);
        if (md != 2)
            for (int k = 0; k < NG; k++) if (m[k]) exp_res[k] = pattern(k, s);
        check_results($sformatf("res_%b", m));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gate_reset"}, gate_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_begin_calc"}, begin_calc, 0);
        check({tag, "_gate_sel"}, gate_sel, 0);
        check({tag, "_error"}, error, 0);
        for (int k = 0; k < NG; k++) exp_res[k] = '0;
        check_results(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        gate_en     = '0;
        data_ready  = 1'b0;
        gate_output = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // All gates, spec pattern, plus literal pins of the model.
        run(4'b1111, 0, 0, 57, 0);
        check("pin_slice0_lane0", result[BW-1:0], 18'h00400);
        check("pin_slice3_lane31", result[3*LB + 31*BW +: BW], 18'h00403);
        check("pin_slice2_lane7", result[2*LB + 7*BW +: BW], 18'h00402);

        // Sparse mask with a start poke while busy; slices 0 and 2 untouched.
        run(4'b1010, 0, 1, model_latency(4'b1010), 8);
        check("pin_slice0_kept", result[BW-1:0], 18'h00400);

        // Empty mask: done 5 cycles after start, no begin_calc.
        run(4'b0000, 0, 2, 5, 0);

        // Stale data_ready level present before each begin_calc.
        data_ready  = 1'b1;
        gate_output = '1;
        run(4'b0110, 1, 5, model_latency(4'b0110), 0);
        mode = 0;
        @(posedge clock); #1;

        // Reset while waiting on gate 2, then a clean restart from gate 0.
        salt    = 3;
        gate_en = 4'b1111;
        start   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (begin_calc && gate_sel == 2'd2) break;
        end
        check("reached_gate2", {62'd0, gate_sel}, 2);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_state("midreset");
        reset = 1'b0;
        run(4'b1111, 0, 4, 57, 0);

`ifdef LSTM_GATE_SCHED_WATCHDOG_EN
        // Gate 1 never answers: watchdog after 16 WAIT cycles.
        exp_error = 1'b1;
        run(4'b0010, 2, 6, 1 + 1 + 3 + 16, 0);
        check("error_set", error, 1);
        repeat (5) @(posedge clock);
        #1;
        check("error_sticky", error, 1);
        run(4'b0001, 0, 7, 1 + 14 + 3, 0);
        check("error_sticky_run", error, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        exp_error = 1'b0;
        check("error_cleared", error, 0);
        reset = 1'b0;
`endif

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
